encoder42_filt: RTL and testbench
=================================

Name: encoder42_filt

Overview:
- Registered 4-to-2 priority encoder: the return path for the team's 2-to-4 decoder.
- Takes four active-low request lines, matching the decoder's output polarity, plus an active-low enable, and encodes the highest-priority asserted line.
- A stability filter rejects glitches on the request lines.
- Each committed change of the encoded value is delivered as an event on a valid/ready handshake to downstream control logic.

Parameters:
- STABLE_CYCLES, 3: number of consecutive identical clock-edge samples required before a new encoded value is committed. Legal range is 1..15; 1 means no filtering.
- CNT_W, 4: width of the stability counter. Must hold STABLE_CYCLES.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  active-low enable; en=1 forces the raw input to be treated as "no request".
- y_n  input  4  active-low request lines; inputs are synchronous to clk; bit 3 has the highest priority.
- code  output  2  encoded index of the committed value.
- any  output  1  1 when at least one request was asserted in the committed value.
- vld  output  1  event valid.
- rdy  input  1  consumer ready.
- ovf  output  1  sticky flag; a stable change was held off because an event was pending.

Behaviour:
- Raw encode (combinational):
  - raw_any = en==0 and y_n != 4'b1111.
  - raw_code = index of the highest bit with y_n[i]==0.
  - When raw_any==0, raw_code = 2'b00.
- Filter state: candidate {cand_any, cand_code}, counter cnt, and committed value {com_any, com_code}.
- Each edge, when raw differs from candidate: candidate <= raw, cnt <= 1.
- Each edge, when raw equals candidate and cnt < STABLE_CYCLES: cnt <= cnt+1.
- "Stable" means cnt == STABLE_CYCLES and raw == candidate.
- Output FSM has two states, IDLE (vld=0) and PEND (vld=1).
  - IDLE, stable and candidate != committed: committed <= candidate; code/any <= candidate; go to PEND.
  - PEND, rdy=1: transfer completes. If a stable differing candidate exists in the same cycle, load it and stay in PEND, so vld stays 1 with no bubble. Otherwise go to IDLE.
  - PEND, rdy=0: code/any hold.
  - PEND, rdy=0, stable and candidate != committed: committed is not updated; ovf <= 1. The event fires once the handshake completes. Intermediate values are coalesced, and the latest stable value is always delivered.
- Latency: a raw change present before edge k, held through edge k+STABLE_CYCLES-1, raises vld after edge k+STABLE_CYCLES-1. That is STABLE_CYCLES edges in total.
- Enable:
  - Deasserting enable (en 0->1) is a raw change to {0,00}.
  - It yields a release event after filtering if the committed value had any=1.
- Reset (rst_n=0, asynchronous, including mid-operation):
  - code=00, any=0, vld=0, ovf=0.
  - committed={0,00}, candidate={0,00}, cnt=0, FSM=IDLE.
  - A pending event is discarded.
- After reset release, lines stable at "no request" generate no event, because candidate equals committed.
- vld and code/any are driven only from registers; no combinational path from y_n or rdy to outputs.
- ovf clears only on reset.

Decomposition:
- Shared package encoder_pkg:
  - Constants REQ_W=4 and CODE_W=2.
  - Typedef enc_val_t {any, code}.
  - Pure function prio_enc4 (active-low in, enc_val_t out), reusable by the bench model.
- One natural sub-module: encoder_stab_filter. It holds candidate and cnt and outputs stable plus cand_val.
- The top holds the committed value, the FSM and ovf.

Test Plan:
- Reset mid-PEND:
  - Stimulus: drive y_n=4'b1011, rdy=0; wait for vld; pulse rst_n low.
  - Required: vld, code, any and ovf go to 0 immediately, with no clock needed.
- Basic encode, STABLE_CYCLES=3:
  - Stimulus: en=0, rdy=1; y_n changes 1111->1101 before edge k.
  - Required: vld=1 with code=01, any=1 after edge k+2; vld low the next cycle.
- Priority:
  - Stimulus: y_n=4'b0110.
  - Required: code=11; then y_n=4'b1110 -> code=00, any=1.
- Glitch rejection:
  - Stimulus: y_n=1110 for 2 cycles, then back to 1111.
  - Required: no vld; no state change.
- Backpressure:
  - Stimulus: rdy=0 with a pending code=01; lines change to 1011 and stay stable.
  - Required: code holds 01; ovf=1. Then rdy=1 -> transfer, and the next vld carries code=10 with no bubble cycle.
- Enable:
  - Stimulus: with a committed code=11/any=1, set en=1.
  - Required: after 3 edges, event code=00, any=0.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types and helpers for the 4-to-2 request encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: request/code widths, the encoded-value struct and a pure
// active-low priority encode function usable by RTL and models alike.
package encoder_pkg;

    localparam int REQ_W  = 4;
    localparam int CODE_W = 2;

    typedef struct packed {
        logic              any;
        logic [CODE_W-1:0] code;
    } enc_val_t;

    // Active-low priority encode: the highest index with a 0 wins.
    // Scanning upward lets later (higher) hits overwrite earlier ones.
    function automatic enc_val_t prio_enc4(input logic [REQ_W-1:0] req_n);
        enc_val_t r;
        r.any  = 1'b0;
        r.code = '0;
        for (int i = 0; i < REQ_W; i++) begin
            if (!req_n[i]) begin
                r.any  = 1'b1;
                r.code = CODE_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/encoder_stab_filter.sv
// Stability filter: tracks a candidate encoded value and how many consecutive
// edges it has been seen. Latency: stable_o asserts combinationally in the
// cycle whose edge completes STABLE_CYCLES samples. Backpressure: none.
//
// Ports:
//   clk, rst_n  clock / async active-low reset
//   raw_i       unfiltered encoded value sampled every edge
//   stable_o    this edge completes (or continues) a run of STABLE_CYCLES
//   cand_o      the value that run refers to
module encoder_stab_filter
    import encoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_W         = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  enc_val_t raw_i,
    output logic     stable_o,
    output enc_val_t cand_o
);

    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

    enc_val_t         cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (raw_i != cand_q) begin
            cand_d = raw_i;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q < STABLE_C) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stability is judged on next-state so the committing edge is the one
    // that takes the Nth sample, not one edge later. Once saturated, cnt_d
    // holds STABLE_C only while raw still matches, so this also covers the
    // "cnt == STABLE_CYCLES and raw == candidate" case; cand_d equals raw
    // whenever stable_o is high.
    assign stable_o = (cnt_d == STABLE_C);
    assign cand_o   = cand_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/encoder42_filt.sv
// Registered, glitch-filtered 4-to-2 priority encoder emitting change events.
// Latency: STABLE_CYCLES edges from a raw change to vld.
// Backpressure: while vld is held off by rdy=0, newer stable values are
// coalesced (ovf set sticky) and the latest one is sent right after the handshake.
//
// Ports:
//   clk, rst_n  clock / async active-low reset
//   en          active-low enable (1 = treat as no request)
//   y_n[3:0]    active-low requests, bit 3 highest priority
//   code, any   committed encoded value (registered)
//   vld, rdy    event handshake
//   ovf         sticky: a stable change waited behind a pending event
module encoder42_filt
    import encoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [REQ_W-1:0]  y_n,
    output logic [CODE_W-1:0] code,
    output logic              any,
    output logic              vld,
    input  logic              rdy,
    output logic              ovf
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    enc_val_t raw_val;
    enc_val_t cand_val;
    logic     stable;
    logic     new_val;

    // The committed value is exactly what code/any present, so one register
    // serves both roles.
    enc_val_t   com_q,   com_d;
    logic [0:0] state_q, state_d;
    logic       ovf_q,   ovf_d;

    assign raw_val = prio_enc4(en ? {REQ_W{1'b1}} : y_n);

    encoder_stab_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_i    (raw_val),
        .stable_o (stable),
        .cand_o   (cand_val)
    );

    assign new_val = stable && (cand_val != com_q);

    always_comb begin
        state_d = state_q;
        com_d   = com_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (new_val) begin
                    com_d   = cand_val;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (rdy) begin
                    // Back-to-back: reload in the accepting cycle, no bubble.
                    if (new_val) begin
                        com_d = cand_val;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (new_val) begin
                    // Held off; the filter keeps it stable so it is picked
                    // up once the pending event drains.
                    ovf_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            com_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            com_q   <= com_d;
            ovf_q   <= ovf_d;
        end
    end

    assign code = com_q.code;
    assign any  = com_q.any;
    assign vld  = (state_q == ST_PEND);
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_encoder42_filt.sv
// Bench for encoder42_filt: directed scenarios followed by randomized traffic,
// with a sample-window reference model feeding an event scoreboard.
// Inputs are driven 2 time units after each rising edge; outputs sampled on
// the falling edge (monitor) or 1 unit after the rising edge (directed checks).
module tb_encoder42_filt;
    import encoder_pkg::*;

    localparam int S = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       rdy   = 1'b0;
    logic [3:0] y_n   = 4'hF;
    logic [1:0] code;
    logic       any;
    logic       vld;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    encoder42_filt #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .y_n   (y_n),
        .code  (code),
        .any   (any),
        .vld   (vld),
        .rdy   (rdy),
        .ovf   (ovf)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Value seen at an edge: first zero bit from the top, or nothing.
    function automatic enc_val_t ref_raw(input logic [3:0] y, input logic e);
        enc_val_t r;
        r = '0;
        if (!e) begin
            for (int i = 3; i >= 0; i--) begin
                if (y[i] == 1'b0) begin
                    r.any  = 1'b1;
                    r.code = 2'(i);
                    break;
                end
            end
        end
        return r;
    endfunction

    enc_val_t hist[$];     // last S samples since reset
    enc_val_t exp_q[$];    // events expected to be presented, in order
    enc_val_t m_raw;
    enc_val_t m_com  = '0; // last value handed to the event channel
    bit       m_pend = 1'b0;
    bit       m_ovf  = 1'b0;
    bit       m_stb;

    // Stable = the last S samples taken since reset are all identical.
    // The event channel is free at an edge unless an event is pending and
    // not being accepted at that same edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                hist.delete();
                exp_q.delete();
                m_com  = '0;
                m_pend = 1'b0;
                m_ovf  = 1'b0;
            end else begin
                m_raw = ref_raw(y_n, en);
                hist.push_back(m_raw);
                if (hist.size() > S) void'(hist.pop_front());
                m_stb = (hist.size() == S);
                foreach (hist[i]) if (hist[i] != m_raw) m_stb = 1'b0;
                if (m_pend && !rdy) begin
                    if (m_stb && m_raw != m_com) m_ovf = 1'b1;
                end else if (m_stb && m_raw != m_com) begin
                    m_com  = m_raw;
                    m_pend = 1'b1;
                    exp_q.push_back(m_raw);
                end else begin
                    m_pend = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit       pv  = 1'b0; // vld at previous sample
    bit       phs = 1'b0; // handshake happened at the edge since previous sample
    enc_val_t got;
    enc_val_t want;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("vld_vs_model", 8'(vld), 8'(m_pend));
                chk("ovf_vs_model", 8'(ovf), 8'(m_ovf));
                if (vld && (!pv || phs)) begin
                    got.any  = any;
                    got.code = code;
                    if (exp_q.size() == 0) begin
                        chk("spurious_event", 8'(got), 8'hEE);
                    end else begin
                        want = exp_q.pop_front();
                        chk("event_value", 8'(got), 8'(want));
                    end
                end
                pv  = vld;
                phs = vld && rdy;
            end else begin
                pv  = 1'b0;
                phs = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] y, input logic e, input logic r);
        y_n = y;
        en  = e;
        rdy = r;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_vld(input string name, input int max);
        int k;
        k = 0;
        while (!vld && k < max) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk(name, 8'(vld), 8'd1);
    endtask

    initial begin
        // Reset state
        drive(4'hF, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_vld",  8'(vld),  8'd0);
        chk("rst_code", 8'(code), 8'd0);
        chk("rst_any",  8'(any),  8'd0);
        chk("rst_ovf",  8'(ovf),  8'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle lines after reset: no event (monitor flags any)
        cycles(6);

        // Basic encode and exact latency
        drive(4'b1101, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("basic_vld_timing", 8'(vld), 8'(i == 2));
        end
        chk("basic_code", 8'(code), 8'd1);
        chk("basic_any",  8'(any),  8'd1);
        @(posedge clk);
        #1 chk("basic_vld_drop", 8'(vld), 8'd0);
        #1;
        cycles(3);

        // Priority
        drive(4'b0110, 1'b0, 1'b1);
        wait_vld("prio_wait_a", 10);
        chk("prio_code_11", 8'(code), 8'd3);
        cycles(4);
        drive(4'b1110, 1'b0, 1'b1);
        wait_vld("prio_wait_b", 10);
        chk("prio_code_00", 8'(code), 8'd0);
        chk("prio_any_1",   8'(any),  8'd1);
        cycles(4);

        // Release, then a 2-cycle glitch that must be rejected
        drive(4'hF, 1'b0, 1'b1);
        cycles(6);
        drive(4'b1110, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cycles(1);
            chk("glitch_no_vld", 8'(vld), 8'd0);
        end
        drive(4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycles(1);
            chk("glitch_no_vld", 8'(vld), 8'd0);
        end
        chk("glitch_any_held", 8'(any), 8'd0);

        // Backpressure with coalescing, then no-bubble reload
        drive(4'b1101, 1'b0, 1'b0);
        wait_vld("bp_wait", 10);
        chk("bp_code_01", 8'(code), 8'd1);
        drive(4'b1011, 1'b0, 1'b0);
        cycles(5);
        chk("bp_code_hold", 8'(code), 8'd1);
        chk("bp_ovf_set",   8'(ovf),  8'd1);
        drive(4'b1011, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("bp_no_bubble", 8'(vld),  8'd1);
        chk("bp_code_10",   8'(code), 8'd2);
        #1;
        cycles(4);

        // Enable release
        drive(4'b0110, 1'b0, 1'b1);
        wait_vld("en_wait", 10);
        chk("en_code_11", 8'(code), 8'd3);
        cycles(3);
        drive(4'b0110, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("en_vld_timing", 8'(vld), 8'(i == 2));
        end
        chk("en_code_00", 8'(code), 8'd0);
        chk("en_any_0",   8'(any),  8'd0);
        #1;
        cycles(3);

        // Asynchronous reset while an event is pending (ovf is still set)
        drive(4'b1011, 1'b0, 1'b0);
        wait_vld("rstp_wait", 10);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstp_vld",  8'(vld),  8'd0);
        chk("rstp_code", 8'(code), 8'd0);
        chk("rstp_any",  8'(any),  8'd0);
        chk("rstp_ovf",  8'(ovf),  8'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive(4'hF, 1'b0, 1'b1);
        cycles(6);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) y_n = 4'($urandom);
            en  = ($urandom_range(19) == 0);
            rdy = 1'($urandom_range(1));
            cycles(1);
        end

        // Drain
        rdy = 1'b1;
        cycles(S + 6);
        chk("drain_queue_empty", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
